// File: rtl/timekeeper_pkg.sv
// Shared codes and constants for the timekeeper block.
// Mode and appliance-state encodings, carry limits, and a small clamp helper.
package timekeeper_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_LOAD_CLK = 2'b01,
        MODE_LOAD_THR = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    localparam logic [1:0] ST_WORK  = 2'b01;
    localparam logic [1:0] ST_CLEAR = 2'b11;

    localparam logic [5:0] SEC_LAST       = 6'd59;
    localparam logic [5:0] MIN_LAST       = 6'd59;
    localparam logic [5:0] WORK_SAT_HOURS = 6'd63;

    function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/hms_counter.sv
// HH:MM:SS counter with clear > load > increment priority.
// SATURATE=1 holds at (HOURS_MAX-1):59:59 instead of wrapping to 00:00:00.
module hms_counter
    import timekeeper_pkg::*;
#(
    parameter int HOURS_MAX = 24,
    parameter bit SATURATE  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [5:0] load_hour_i,
    input  logic [5:0] load_min_i,
    input  logic       clr_i,
    output logic [5:0] hour_o,
    output logic [5:0] min_o,
    output logic [5:0] sec_o
);

    localparam logic [5:0] HOUR_LAST = 6'(HOURS_MAX - 1);

    logic [5:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       at_max;

    assign at_max = (hour_q == HOUR_LAST) && (min_q == MIN_LAST) && (sec_q == SEC_LAST);

    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (clr_i) begin
            hour_d = '0;
            min_d  = '0;
            sec_d  = '0;
        end else if (load_i) begin
            hour_d = load_hour_i;
            min_d  = load_min_i;
            sec_d  = '0;
        end else if (inc_i && !(SATURATE && at_max)) begin
            // Carries ripple within the same cycle so no 60 is ever stored.
            if (sec_q == SEC_LAST) begin
                sec_d = '0;
                if (min_q == MIN_LAST) begin
                    min_d  = '0;
                    hour_d = (hour_q == HOUR_LAST) ? 6'd0 : hour_q + 6'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_q <= '0;
            min_q  <= '0;
            sec_q  <= '0;
        end else begin
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
        end
    end

    assign hour_o = hour_q;
    assign min_o  = min_q;
    assign sec_o  = sec_q;

endmodule

// File: rtl/timekeeper_multi.sv
// Time-of-day clock plus saturating work-time accumulator with sticky reminder.
// Define REMIND_MINUTE_RES_EN to compare the reminder threshold at minute resolution.
module timekeeper_multi
    import timekeeper_pkg::*;
#(
    parameter int CLK_HZ         = 100,
    parameter int TICK_HZ        = 1,
    parameter int HOURS_MAX      = 24,
    parameter int REMIND_DEFAULT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_on,
    input  logic [1:0] mode,
    input  logic [5:0] set_hour,
    input  logic [5:0] set_minute,
    input  logic [1:0] state,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [5:0] work_hours,
    output logic [5:0] work_minutes,
    output logic [5:0] work_seconds,
    output logic       remind,
    output logic       sec_tick
);

    localparam int             DIV       = CLK_HZ / TICK_HZ;
    localparam int             CW        = $clog2(DIV);
    localparam logic [CW-1:0]  PS_LAST   = CW'(DIV - 1);
    localparam logic [5:0]     HOUR_LAST = 6'(HOURS_MAX - 1);

    mode_e         mode_m;
    logic [CW-1:0] ps_q, ps_d;
    logic          tick;
    logic          tod_inc, tod_load;
    logic          work_inc, work_clr;
    logic [5:0]    thr_h_q, thr_h_d;
    logic          remind_q, remind_d;
    logic          reached;

    assign mode_m = mode_e'(mode);
    assign tick   = (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q + CW'(1);
        if (!power_on || mode_m == MODE_LOAD_CLK || tick) begin
            ps_d = '0;
        end
    end

    assign tod_load = (mode_m == MODE_LOAD_CLK);
    assign tod_inc  = tick && (mode_m == MODE_RUN);
    // Loading the clock restarts the prescaler, so a pending tick is dropped there too.
    assign work_inc = tick && (state == ST_WORK) &&
                      (mode_m != MODE_LOAD_THR) && (mode_m != MODE_LOAD_CLK);
    assign work_clr = (state == ST_CLEAR);

    hms_counter #(
        .HOURS_MAX (HOURS_MAX),
        .SATURATE  (1'b0)
    ) u_tod (
        .clk         (clk),
        .rst         (reset),
        .inc_i       (tod_inc),
        .load_i      (tod_load),
        .load_hour_i (clamp6(set_hour, HOUR_LAST)),
        .load_min_i  (clamp6(set_minute, MIN_LAST)),
        .clr_i       (1'b0),
        .hour_o      (hour),
        .min_o       (minute),
        .sec_o       (second)
    );

    hms_counter #(
        .HOURS_MAX (int'(WORK_SAT_HOURS) + 1),
        .SATURATE  (1'b1)
    ) u_work (
        .clk         (clk),
        .rst         (reset),
        .inc_i       (work_inc),
        .load_i      (1'b0),
        .load_hour_i (6'd0),
        .load_min_i  (6'd0),
        .clr_i       (work_clr),
        .hour_o      (work_hours),
        .min_o       (work_minutes),
        .sec_o       (work_seconds)
    );

    assign thr_h_d = (mode_m == MODE_LOAD_THR) ? set_hour : thr_h_q;

`ifdef REMIND_MINUTE_RES_EN
    logic [5:0] thr_m_q, thr_m_d;
    assign thr_m_d = (mode_m == MODE_LOAD_THR) ? clamp6(set_minute, MIN_LAST) : thr_m_q;
    assign reached = ({work_hours, work_minutes} >= {thr_h_q, thr_m_q});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) thr_m_q <= '0;
        else       thr_m_q <= thr_m_d;
    end
`else
    assign reached = (work_hours >= thr_h_q);
`endif

    always_comb begin
        remind_d = remind_q;
        if (work_clr) begin
            remind_d = 1'b0;
        end else if (state == ST_WORK && reached) begin
            remind_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q     <= '0;
            thr_h_q  <= 6'(REMIND_DEFAULT);
            remind_q <= 1'b0;
        end else begin
            ps_q     <= ps_d;
            thr_h_q  <= thr_h_d;
            remind_q <= remind_d;
        end
    end

    assign remind   = remind_q;
    assign sec_tick = tick;

endmodule

// File: doc/timekeeper_multi.md
Name: timekeeper_multi

Overview:
Parametrised timekeeping block for the appliance controller.
- Keeps an HH:MM:SS time of day and an HH:MM:SS work-time accumulator.
- Raises a sticky reminder when accumulated work time reaches a programmable threshold.
- Runs on the single system clock. An internal prescaler makes a one-cycle second tick, so there is no separate slow clock.
- Sits between the button/mode decoder (set values, mode) and the display/alarm logic (time outputs, remind).

Parameters:
- CLK_HZ, 100, system clock frequency in Hz.
- TICK_HZ, 1, tick rate in Hz. DIV = CLK_HZ/TICK_HZ, must be ≥ 2.
- HOURS_MAX, 24, time-of-day hour modulus (0..HOURS_MAX-1), ≤ 64.
- REMIND_DEFAULT, 10, reminder threshold in hours after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- power_on  in  1  1 = time of day advances
- mode  in  2  00 run, 01 load clock, 10 load remind threshold, 11 hold
- set_hour  in  6  hour value for loads
- set_minute  in  6  minute value for loads
- state  in  2  appliance state: 01 working (accumulate), 11 clear work time, others idle
- hour  out  6  time-of-day hour
- minute  out  6  time-of-day minute
- second  out  6  time-of-day second
- work_hours  out  6  accumulated work hours
- work_minutes  out  6  accumulated work minutes
- work_seconds  out  6  accumulated work seconds
- remind  out  1  sticky work-time reminder
- sec_tick  out  1  one-cycle pulse per tick

Behaviour:
- Reset (async, active-high): all counters and outputs 0; threshold = REMIND_DEFAULT; remind = 0; prescaler = 0.
- Prescaler:
  - While power_on=1 and mode≠01, counts 0..DIV-1.
  - sec_tick=1 in the cycle the count equals DIV-1, then wraps to 0.
  - power_on=0: prescaler held at 0, sec_tick=0.
- Time of day (mode=00):
  - On sec_tick, second increments.
  - second 59→0 carries into minute in the same cycle; minute 59→0 carries into hour in the same cycle.
  - hour HOURS_MAX-1→0.
  - No out-of-range value (second/minute 60, hour HOURS_MAX) is ever visible.
- mode=01 (load clock), each cycle:
  - hour ← min(set_hour, HOURS_MAX-1); minute ← min(set_minute, 59); second ← 0; prescaler ← 0.
  - The first tick after leaving 01 arrives DIV cycles later.
- mode=11: time of day frozen; prescaler keeps running.
- mode=10: threshold ← set_hour, every cycle; the time of day does not advance.
- Work accumulator:
  - On sec_tick with state=01 and mode≠10: increments with the same carry rules.
  - Saturates at 63:59:59 (no wrap).
- state=11: clears work_hours, work_minutes and work_seconds to 0 and remind to 0 next edge. This has priority over accumulation and over the remind set.
- remind:
  - Set next edge when state=01 and work_hours ≥ threshold, evaluated every cycle, not only on ticks.
  - Stays set until state=11 or reset.
  - Threshold 0 → remind asserts one cycle after state=01 is seen.
- Simultaneous events:
  - A tick during mode=01 is ignored, because the prescaler is held.
  - A threshold change while remind=1 does not clear remind.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: REMIND_MINUTE_RES_EN.
- Defined:
  - mode=10 also loads threshold minutes ← min(set_minute, 59).
  - remind condition becomes {work_hours, work_minutes} ≥ {thr_h, thr_m}.
  - Threshold minutes reset to 0.
- Undefined: minute threshold logic is absent; only hours are compared.

Decomposition:
- Package timekeeper_pkg:
  - mode codes MODE_RUN, MODE_LOAD_CLK, MODE_LOAD_THR, MODE_HOLD;
  - state codes ST_WORK=2'b01, ST_CLEAR=2'b11;
  - constants SEC_LAST=59, MIN_LAST=59, WORK_SAT_HOURS=63.
- Sub-module hms_counter:
  - Parameters HOURS_MAX and SATURATE.
  - Ports: inc enable, load enable with load values, clear, H/M/S outputs.
  - Instantiated twice: time of day with wrap, work time with saturate.

Test Plan (CLK_HZ=4, TICK_HZ=1 → DIV=4):
1. Reset, power_on=1, mode=00 for 16 cycles → sec_tick pulses at cycles 4, 8, 12, 16; second=4.
2. mode=01 with set 23/59, then mode=00 → loads 23:59:00; after 60 ticks reads 00:00:00 with no intermediate 60 value.
3. mode=01 with set_hour=40, set_minute=70 → hour=23, minute=59, second=0.
4. Threshold set to 0 via mode=10, then state=01 → remind=1 on the second edge; state=11 → remind=0 and work time 00:00:00 next edge.
5. Work time forced near 63:59:58 with state=01 → after 3 ticks stays 63:59:59.
6. Reset asserted mid-count (hour=5, work_hours=3, remind=1) → all outputs 0 and threshold 10 immediately, without waiting for a clock edge.
